mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 157 +++++++++++++++
 tb/tb_mem_access.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : Memory-access pipeline stage. Issues one 8-byte data-bus
//               request per aligned load/store and forwards results to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  // execute-stage input
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [5:0]      in_op,
  input  logic            in_regwrite,
  input  logic            in_memread,
  input  logic            in_memwrite,
  input  logic [XLEN-1:0] in_result,
  input  logic [XLEN-1:0] in_wd,
  input  logic [RA_W-1:0] in_wa,
  output logic            in_ready,
  // data-bus request
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [2:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  // data-bus response
  input  logic            dresp_addr_ok,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data,
  // writeback output
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [5:0]      out_op,
  output logic            out_regwrite,
  output logic [XLEN-1:0] out_result,
  output logic [RA_W-1:0] out_wa,
  output logic            out_misalign
);

  localparam logic [2:0] c_dreq_size = 3'b011;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic            w_accept;
  logic            w_is_mem;
  logic            w_misalign;
  logic            w_start;
  logic            w_done;
  logic            w_unused_addr_ok;

  logic [XLEN-1:0] r_req_addr;
  logic [XLEN-1:0] r_req_data;
  logic [7:0]      r_req_strobe;
  logic [XLEN-1:0] r_pend_pc;
  logic [5:0]      r_pend_op;
  logic            r_pend_regwrite;
  logic            r_pend_load;
  logic [RA_W-1:0] r_pend_wa;

  // The bus only reports completion through data_ok; address acceptance is irrelevant here.
  assign w_unused_addr_ok = dresp_addr_ok;

  assign in_ready   = (r_state == ST_IDLE);
  assign w_accept   = in_valid & in_ready;
  assign w_is_mem   = in_memread | in_memwrite;
  assign w_misalign = w_is_mem & (|in_result[2:0]);
  assign w_start    = w_accept & w_is_mem & ~w_misalign;
  assign w_done     = (r_state == ST_BUSY) & dresp_data_ok;

  assign dreq_valid  = (r_state == ST_BUSY);
  assign dreq_addr   = r_req_addr;
  assign dreq_size   = c_dreq_size;
  assign dreq_strobe = r_req_strobe;
  assign dreq_data   = r_req_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next_state = ST_BUSY;
      ST_BUSY: if (dresp_data_ok) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Request and pending-instruction registers, loaded once per aligned memory op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_addr      <= '0;
      r_req_data      <= '0;
      r_req_strobe    <= 8'h00;
      r_pend_pc       <= '0;
      r_pend_op       <= 6'd0;
      r_pend_regwrite <= 1'b0;
      r_pend_load     <= 1'b0;
      r_pend_wa       <= '0;
    end else if (w_start) begin
      r_req_addr      <= in_result;
      r_req_data      <= in_wd;
      r_req_strobe    <= in_memwrite ? 8'hFF : 8'h00;
      r_pend_pc       <= in_pc;
      r_pend_op       <= in_op;
      r_pend_regwrite <= in_regwrite;
      r_pend_load     <= in_memread;
      r_pend_wa       <= in_wa;
    end
  end

  // Writeback register: data fields only change on a completion, so they hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_op       <= 6'd0;
      out_regwrite <= 1'b0;
      out_result   <= '0;
      out_wa       <= '0;
      out_misalign <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (w_accept && !w_start) begin
        out_valid    <= 1'b1;
        out_pc       <= in_pc;
        out_op       <= in_op;
        out_regwrite <= in_regwrite & ~w_misalign;
        out_result   <= in_result;
        out_wa       <= in_wa;
        out_misalign <= w_misalign;
      end else if (w_done) begin
        out_valid    <= 1'b1;
        out_pc       <= r_pend_pc;
        out_op       <= r_pend_op;
        out_regwrite <= r_pend_regwrite;
        out_result   <= r_pend_load ? dresp_data : r_req_addr;
        out_wa       <= r_pend_wa;
        out_misalign <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Directed self-checking bench for mem_access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

  localparam int XLEN = 64;
  localparam int RA_W = 5;
  localparam logic [5:0] OP_ADD = 6'h01;
  localparam logic [5:0] OP_LD  = 6'h10;
  localparam logic [5:0] OP_SD  = 6'h18;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [5:0]      in_op;
  logic            in_regwrite, in_memread, in_memwrite;
  logic [XLEN-1:0] in_result, in_wd;
  logic [RA_W-1:0] in_wa;
  logic            in_ready;
  logic            dreq_valid;
  logic [XLEN-1:0] dreq_addr;
  logic [2:0]      dreq_size;
  logic [7:0]      dreq_strobe;
  logic [XLEN-1:0] dreq_data;
  logic            dresp_addr_ok, dresp_data_ok;
  logic [XLEN-1:0] dresp_data;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [5:0]      out_op;
  logic            out_regwrite;
  logic [XLEN-1:0] out_result;
  logic [RA_W-1:0] out_wa;
  logic            out_misalign;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_op(in_op),
    .in_regwrite(in_regwrite), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_result(in_result), .in_wd(in_wd), .in_wa(in_wa), .in_ready(in_ready),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_op(out_op), .out_regwrite(out_regwrite),
    .out_result(out_result), .out_wa(out_wa), .out_misalign(out_misalign)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [XLEN-1:0] pc,
                       input logic rw, input logic mr, input logic mw,
                       input logic [XLEN-1:0] res, input logic [XLEN-1:0] wd,
                       input logic [RA_W-1:0] wa);
    in_valid = 1'b1; in_op = op; in_pc = pc; in_regwrite = rw;
    in_memread = mr; in_memwrite = mw; in_result = res; in_wd = wd; in_wa = wa;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_op = '0; in_regwrite = 1'b0;
    in_memread = 1'b0; in_memwrite = 1'b0; in_result = '0; in_wd = '0; in_wa = '0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    #3;
    n_cmp++; if (dreq_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dreq_valid got %b exp 0", dreq_valid); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_result !== 64'h0 || out_pc !== 64'h0) begin n_bad++; $display("FAIL rst_out_data got %h/%h exp 0/0", out_result, out_pc); end
    n_cmp++; if (dreq_size !== 3'b011) begin n_bad++; $display("FAIL rst_dreq_size got %b exp 011", dreq_size); end
    tick; tick;
    reset = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_add;
    drive(OP_ADD, 64'h8000_0000, 1'b1, 1'b0, 1'b0, 64'h5, 64'h0, 5'd3);
    tick;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid got %b exp 1", out_valid); end
    n_cmp++; if (out_result !== 64'h5) begin n_bad++; $display("FAIL add_result got %h exp 5", out_result); end
    n_cmp++; if (out_wa !== 5'd3 || out_pc !== 64'h8000_0000 || out_op !== OP_ADD) begin n_bad++; $display("FAIL add_fields got wa=%0d pc=%h op=%h exp 3/80000000/01", out_wa, out_pc, out_op); end
    n_cmp++; if (out_misalign !== 1'b0 || out_regwrite !== 1'b1) begin n_bad++; $display("FAIL add_flags got mis=%b rw=%b exp 0/1", out_misalign, out_regwrite); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL add_ready got %b exp 1", in_ready); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_pulse got %b exp 0", out_valid); end
    n_cmp++; if (out_result !== 64'h5) begin n_bad++; $display("FAIL add_hold got %h exp 5", out_result); end
  endtask

  task automatic test_load;
    drive(OP_LD, 64'h8000_0100, 1'b1, 1'b1, 1'b0, 64'h8000_0010, 64'h0, 5'd5);
    tick;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ld_accept_valid got %b exp 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (dreq_valid !== 1'b1) begin n_bad++; $display("FAIL ld_dreq_valid[%0d] got %b exp 1", i, dreq_valid); end
      n_cmp++; if (dreq_addr !== 64'h8000_0010 || dreq_strobe !== 8'h00) begin n_bad++; $display("FAIL ld_req[%0d] got %h/%h exp 80000010/00", i, dreq_addr, dreq_strobe); end
      n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL ld_busy[%0d] got rdy=%b ov=%b exp 0/0", i, in_ready, out_valid); end
      if (i == 2) begin dresp_data_ok = 1'b1; dresp_data = 64'hDEAD_BEEF; end
      tick;
    end
    dresp_data_ok = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ld_out_valid got %b exp 1", out_valid); end
    n_cmp++; if (out_result !== 64'hDEAD_BEEF) begin n_bad++; $display("FAIL ld_out_result got %h exp deadbeef", out_result); end
    n_cmp++; if (out_wa !== 5'd5 || out_regwrite !== 1'b1 || out_pc !== 64'h8000_0100) begin n_bad++; $display("FAIL ld_out_fields got wa=%0d rw=%b pc=%h exp 5/1/80000100", out_wa, out_regwrite, out_pc); end
    n_cmp++; if (dreq_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL ld_idle got dv=%b rdy=%b exp 0/1", dreq_valid, in_ready); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ld_pulse got %b exp 0", out_valid); end
  endtask

  task automatic test_store;
    drive(OP_SD, 64'h8000_0200, 1'b0, 1'b0, 1'b1, 64'h8000_0008, 64'h1234, 5'd0);
    tick;
    in_valid = 1'b0;
    n_cmp++; if (dreq_valid !== 1'b1) begin n_bad++; $display("FAIL sd_dreq_valid got %b exp 1", dreq_valid); end
    n_cmp++; if (dreq_strobe !== 8'hFF || dreq_data !== 64'h1234 || dreq_addr !== 64'h8000_0008) begin n_bad++; $display("FAIL sd_req got st=%h d=%h a=%h exp ff/1234/80000008", dreq_strobe, dreq_data, dreq_addr); end
    dresp_data_ok = 1'b1; dresp_data = 64'hFFFF_0000;
    tick;
    dresp_data_ok = 1'b0;
    n_cmp++; if (dreq_valid !== 1'b0) begin n_bad++; $display("FAIL sd_single_req got %b exp 0", dreq_valid); end
    n_cmp++; if (out_valid !== 1'b1 || out_regwrite !== 1'b0) begin n_bad++; $display("FAIL sd_out got ov=%b rw=%b exp 1/0", out_valid, out_regwrite); end
    n_cmp++; if (out_result !== 64'h8000_0008) begin n_bad++; $display("FAIL sd_out_result got %h exp 80000008", out_result); end
    tick;
  endtask

  task automatic test_misalign;
    drive(OP_LD, 64'h8000_0300, 1'b1, 1'b1, 1'b0, 64'h8000_0004, 64'h0, 5'd7);
    tick;
    in_valid = 1'b0;
    n_cmp++; if (dreq_valid !== 1'b0) begin n_bad++; $display("FAIL mis_dreq got %b exp 0", dreq_valid); end
    n_cmp++; if (out_valid !== 1'b1 || out_misalign !== 1'b1 || out_regwrite !== 1'b0) begin n_bad++; $display("FAIL mis_out got ov=%b mis=%b rw=%b exp 1/1/0", out_valid, out_misalign, out_regwrite); end
    n_cmp++; if (out_result !== 64'h8000_0004 || in_ready !== 1'b1) begin n_bad++; $display("FAIL mis_result got %h rdy=%b exp 80000004/1", out_result, in_ready); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mis_pulse got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_busy;
    drive(OP_LD, 64'h8000_0400, 1'b1, 1'b1, 1'b0, 64'h8000_0040, 64'h0, 5'd9);
    tick;
    in_valid = 1'b0;
    n_cmp++; if (dreq_valid !== 1'b1) begin n_bad++; $display("FAIL rb_busy got %b exp 1", dreq_valid); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (dreq_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL rb_async got dv=%b rdy=%b exp 0/1", dreq_valid, in_ready); end
    n_cmp++; if (out_result !== 64'h0 || dreq_addr !== 64'h0) begin n_bad++; $display("FAIL rb_clear got %h/%h exp 0/0", out_result, dreq_addr); end
    tick;
    reset = 1'b0;
    dresp_data_ok = 1'b1; dresp_data = 64'h5555;
    tick;
    dresp_data_ok = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || dreq_valid !== 1'b0) begin n_bad++; $display("FAIL rb_stray got ov=%b dv=%b exp 0/0", out_valid, dreq_valid); end
    n_cmp++; if (in_ready !== 1'b1 || out_result !== 64'h0) begin n_bad++; $display("FAIL rb_after got rdy=%b res=%h exp 1/0", in_ready, out_result); end
  endtask

  task automatic test_back_to_back;
    drive(OP_ADD, 64'h8000_0500, 1'b1, 1'b0, 1'b0, 64'h11, 64'h0, 5'd1);
    tick;
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 64'h11 || out_wa !== 5'd1) begin n_bad++; $display("FAIL b2b_add1 got ov=%b res=%h wa=%0d exp 1/11/1", out_valid, out_result, out_wa); end
    drive(OP_LD, 64'h8000_0504, 1'b1, 1'b1, 1'b0, 64'h8000_0020, 64'h0, 5'd2);
    tick;
    n_cmp++; if (out_valid !== 1'b0 || dreq_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ld_issue got ov=%b dv=%b rdy=%b exp 0/1/0", out_valid, dreq_valid, in_ready); end
    drive(OP_ADD, 64'h8000_0508, 1'b1, 1'b0, 1'b0, 64'h33, 64'h0, 5'd4);
    tick;
    n_cmp++; if (out_valid !== 1'b0 || dreq_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ld_wait got ov=%b dv=%b rdy=%b exp 0/1/0", out_valid, dreq_valid, in_ready); end
    dresp_data_ok = 1'b1; dresp_data = 64'hCAFE;
    tick;
    dresp_data_ok = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 64'hCAFE || out_wa !== 5'd2) begin n_bad++; $display("FAIL b2b_ld_out got ov=%b res=%h wa=%0d exp 1/cafe/2", out_valid, out_result, out_wa); end
    n_cmp++; if (in_ready !== 1'b1 || dreq_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_ld_idle got rdy=%b dv=%b exp 1/0", in_ready, dreq_valid); end
    tick;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 64'h33 || out_wa !== 5'd4) begin n_bad++; $display("FAIL b2b_add3 got ov=%b res=%h wa=%0d exp 1/33/4", out_valid, out_result, out_wa); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_end got %b exp 0", out_valid); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_load;
    test_store;
    test_misalign;
    test_reset_busy;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
